// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised FIFO family.
// Defaults match the original 8-bit x 16-entry buffering stage.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  // Ceiling log2 computed at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Read/write pointer width: pointers wrap naturally at DEPTH.
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Occupancy width: one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read address. Registering the read data is left to the
// parent so it can choose between registered and fall-through reads.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W_DEF,
  parameter int  DEPTH  = FIFO_DEPTH_DEF,
  localparam int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the accepted word at the write address.
  // NOTE: the array has no reset; contents only matter once the pointers say
  // a word is present, and a reset on every entry would turn RAM into flops.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// read-valid strobe.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head word combinationally, rd_valid = ~empty);
// otherwise reads are registered with one cycle of latency.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int  DATA_W    = FIFO_DATA_W_DEF,
  parameter int  DEPTH     = FIFO_DEPTH_DEF,
  parameter int  AF_THRESH = DEPTH - 2,
  parameter int  AE_THRESH = 2,
  localparam int ADDR_W    = ptr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ren,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_LVL   = CNT_W'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] mem_rd_data;
  logic              rd_acc;
  logic              wr_acc;

  // A read needs a stored word. A write needs room, or a same-cycle read
  // that frees a slot, so a full FIFO still streams at one word per cycle.
  // Reading an empty FIFO is rejected even when a write arrives together.
  assign rd_acc = ren & ~empty;
  assign wr_acc = wen & (~full | rd_acc);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wen     (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Next occupancy: simultaneous accepted read and write cancel out.
  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pointers and occupancy; rejected requests leave them untouched.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
    end
  end

  // Status flags decoded from the next count so they move on the same edge
  // as count and drive outputs straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      full         <= (count_nxt == CNT_FULL);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_LVL);
      almost_empty <= (count_nxt <= AE_LVL);
    end
  end

  // Rejection pulses: one cycle, reporting the previous cycle's requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wen & ~wr_acc;
      underflow <= ren & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through: the head word is always presented; ren pops it.
  assign rd_data  = mem_rd_data;
  assign rd_valid = ~empty;
`else
  // Registered read: data and strobe appear after the accepting edge, and
  // rd_data holds its last value while no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem_rd_data;
      end
    end
  end
`endif

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (default build, DATA_W=8, DEPTH=16).
// Read data is checked by a scoreboard: stimulus pushes the hand-computed
// word it expects, and a negedge monitor pops and compares on rd_valid.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wen;
  logic [7:0] wr_data;
  logic       ren;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  sync_fifo_param dut (
    .clk          (clk),
    .rst          (rst),
    .wen          (wen),
    .wr_data      (wr_data),
    .ren          (ren),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; outputs are then sampled 1 ns after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    wen     = w;
    wr_data = d;
    ren     = r;
    @(posedge clk);
    #1;
    wen     = 1'b0;
    ren     = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int c, input logic f, input logic e,
                             input logic af, input logic ae);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_flags(tag, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check({tag, ".rd_data"}, 32'(rd_data), 32'h0);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
    check({tag, ".overflow"}, 32'(overflow), 32'h0);
    check({tag, ".underflow"}, 32'(underflow), 32'h0);
  endtask

  // Scoreboard monitor: every rd_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rd_valid: got rd_valid=1 rd_data=%0h, expected no read", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    wen     = 1'b0;
    ren     = 1'b0;
    wr_data = 8'h00;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill: the first write lands on the first edge after release.
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 8'(k - 1), 1'b0);
      check_flags("fill", k, k == 16, 1'b0, k >= 14, k <= 2);
    end

    // 17th write on a full FIFO is rejected.
    cycle(1'b1, 8'hEE, 1'b0);
    check("fill17.overflow", 32'(overflow), 32'h1);
    check("fill17.count", 32'(count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0);
    check("fill17.overflow_pulse", 32'(overflow), 32'h0);

    // Drain: words 00..0F in order, one rd_valid each.
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(8'(k));
      cycle(1'b0, 8'h00, 1'b1);
      check_flags("drain", 15 - k, 1'b0, k == 15, (15 - k) >= 14, (15 - k) <= 2);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("drain.underflow", 32'(underflow), 32'h1);
    check("drain.count", 32'(count), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("drain.underflow_pulse", 32'(underflow), 32'h0);
    check("drain.pending_reads", 32'(exp_q.size()), 32'd0);

    // Refill with 20..2F, then stream through a full FIFO for four cycles.
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 8'(8'h20 + k), 1'b0);
    end
    check_flags("refill", 16, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'(8'h20 + k));
      cycle(1'b1, 8'(8'h30 + k), 1'b1);
      check("onfull.count", 32'(count), 32'd16);
      check("onfull.full", 32'(full), 32'h1);
      check("onfull.overflow", 32'(overflow), 32'h0);
    end
    // Drain across the pointer wrap: 24..2F then 30..33.
    for (int k = 4; k < 16; k++) begin
      exp_q.push_back(8'(8'h20 + k));
      cycle(1'b0, 8'h00, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'(8'h30 + k));
      cycle(1'b0, 8'h00, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b0);
    check("onfull.drained_count", 32'(count), 32'd0);
    check("onfull.pending_reads", 32'(exp_q.size()), 32'd0);

    // Simultaneous write and read on an empty FIFO.
    cycle(1'b1, 8'hA5, 1'b1);
    check("onempty.underflow", 32'(underflow), 32'h1);
    check("onempty.count", 32'(count), 32'd1);
    check("onempty.empty", 32'(empty), 32'h0);
    exp_q.push_back(8'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("onempty.count_after", 32'(count), 32'd0);
    check("onempty.pending_reads", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream with seven words stored and rd_data = A5.
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 8'(8'h40 + k), 1'b0);
    end
    check("midrst.count_before", 32'(count), 32'd7);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    check("midrst.count_write", 32'(count), 32'd1);
    exp_q.push_back(8'h77);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("midrst.count_read", 32'(count), 32'd0);
    check("midrst.pending_reads", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_param
